// File: rtl/cmplx_arb_pkg.sv
// Shared types and helpers for the complex add/sub arbiter slice.
package cmplx_arb_pkg;

    // Operation select on req_k
    localparam logic K_ADD = 1'b0;
    localparam logic K_SUB = 1'b1;

    // Full-precision width of one complex part at the default operand width
    localparam int unsigned CMPLX_W = 33;

    typedef struct packed {
        logic signed [CMPLX_W-1:0] re;
        logic signed [CMPLX_W-1:0] im;
    } cmplx_t;

    // Requester id width: clog2(n), at least one bit
    function automatic int unsigned idw_f(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/Add_Sub_cmplx.sv
// Complex adder/subtractor, full precision: C = A + B (k=0) or A - B (k=1).
module Add_Sub_cmplx
    import cmplx_arb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] ar_i,
    input  logic [N-1:0] ai_i,
    input  logic [N-1:0] br_i,
    input  logic [N-1:0] bi_i,
    input  logic         k_i,
    output logic [N:0]   cr_o,
    output logic [N:0]   ci_o
);

    // Sign-extend by one bit so the sum or difference can never overflow
    always_comb begin
        logic [N:0] ar_x, ai_x, br_x, bi_x;
        ar_x = {ar_i[N-1], ar_i};
        ai_x = {ai_i[N-1], ai_i};
        br_x = {br_i[N-1], br_i};
        bi_x = {bi_i[N-1], bi_i};
        if (k_i == K_SUB) begin
            cr_o = ar_x - br_x;
            ci_o = ai_x - bi_x;
        end else begin
            cr_o = ar_x + br_x;
            ci_o = ai_x + bi_x;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester strictly after ptr wins (wrapping).
// Purely combinational; the owner of ptr advances it on handshake.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    // Scan from ptr+1 around to ptr, keep the first active request
    always_comb begin
        int unsigned j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            j = (32'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/cmplx_addsub_arb.sv
// Round-robin sharing of one complex add/sub between NREQ requesters,
// with a single registered, backpressured result stage tagged by requester id.
// Optional: define CMPLX_ARB_SAT_EN to clip results to the N-bit range and
// add the sat_flag output.
module cmplx_addsub_arb
    import cmplx_arb_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = idw_f(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_ar,
    input  logic [NREQ*N-1:0] req_ai,
    input  logic [NREQ*N-1:0] req_br,
    input  logic [NREQ*N-1:0] req_bi,
    input  logic [NREQ-1:0]   req_k,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N:0]        res_cr,
    output logic [N:0]        res_ci,
    output logic [IDW-1:0]    res_id,
    output logic [15:0]       op_cnt
`ifdef CMPLX_ARB_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int unsigned CNT_W = 16;

    logic              res_valid_q, res_valid_d;
    logic [N:0]        res_cr_q, res_cr_d;
    logic [N:0]        res_ci_q, res_ci_d;
    logic [IDW-1:0]    res_id_q, res_id_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
    logic              sat_q, sat_d;

    logic [NREQ-1:0]   gnt_c;
    logic [IDW-1:0]    idx_c;
    logic              any_c;
    logic              accept_c;
    logic              hs_c;
    logic [N-1:0]      sel_ar_c, sel_ai_c, sel_br_c, sel_bi_c;
    logic              sel_k_c;
    logic [N:0]        sum_cr_c, sum_ci_c;
    logic [N:0]        out_cr_c, out_ci_c;
    logic              clip_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt_c),
        .idx_o (idx_c),
        .any_o (any_c)
    );

    // Ready only when the result register can take data; none during reset
    always_comb begin
        accept_c  = !res_valid_q || res_ready;
        req_ready = gnt_c & {NREQ{accept_c & rst_n}};
        hs_c      = any_c & accept_c & rst_n;
    end

    // Route the granted requester's operands to the shared datapath
    always_comb begin
        sel_ar_c = req_ar[32'(idx_c)*N +: N];
        sel_ai_c = req_ai[32'(idx_c)*N +: N];
        sel_br_c = req_br[32'(idx_c)*N +: N];
        sel_bi_c = req_bi[32'(idx_c)*N +: N];
        sel_k_c  = req_k[idx_c];
    end

    Add_Sub_cmplx #(
        .N (N)
    ) u_addsub (
        .ar_i (sel_ar_c),
        .ai_i (sel_ai_c),
        .br_i (sel_br_c),
        .bi_i (sel_bi_c),
        .k_i  (sel_k_c),
        .cr_o (sum_cr_c),
        .ci_o (sum_ci_c)
    );

`ifdef CMPLX_ARB_SAT_EN
    // Clip to N-bit range: overflow shows as the top two bits disagreeing
    function automatic logic [N:0] sat_f(input logic [N:0] v);
        if (v[N] != v[N-1]) begin
            return v[N] ? {2'b11, {(N-1){1'b0}}} : {2'b00, {(N-1){1'b1}}};
        end
        return v;
    endfunction

    // Saturated result plus clip indication
    always_comb begin
        out_cr_c = sat_f(sum_cr_c);
        out_ci_c = sat_f(sum_ci_c);
        clip_c   = (sum_cr_c[N] ^ sum_cr_c[N-1]) | (sum_ci_c[N] ^ sum_ci_c[N-1]);
    end

    assign sat_flag = sat_q;
`else
    // Full-precision result passes straight through
    always_comb begin
        out_cr_c = sum_cr_c;
        out_ci_c = sum_ci_c;
        clip_c   = 1'b0;
    end
`endif

    // Result stage, pointer and op counter next-state
    always_comb begin
        res_valid_d = res_valid_q;
        res_cr_d    = res_cr_q;
        res_ci_d    = res_ci_q;
        res_id_d    = res_id_q;
        sat_d       = sat_q;
        ptr_d       = ptr_q;
        op_cnt_d    = op_cnt_q;
        if (hs_c) begin
            res_valid_d = 1'b1;
            res_cr_d    = out_cr_c;
            res_ci_d    = out_ci_c;
            res_id_d    = idx_c;
            sat_d       = clip_c;
            ptr_d       = idx_c;
            op_cnt_d    = op_cnt_q + CNT_W'(1);
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State registers; ptr resets to NREQ-1 so requester 0 is served first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_cr_q    <= '0;
            res_ci_q    <= '0;
            res_id_q    <= '0;
            sat_q       <= 1'b0;
            ptr_q       <= IDW'(NREQ - 1);
            op_cnt_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_cr_q    <= res_cr_d;
            res_ci_q    <= res_ci_d;
            res_id_q    <= res_id_d;
            sat_q       <= sat_d;
            ptr_q       <= ptr_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_cr    = res_cr_q;
    assign res_ci    = res_ci_q;
    assign res_id    = res_id_q;
    assign op_cnt    = op_cnt_q;

endmodule
